opl_slot_seq: RTL and testbench
===============================

Name: opl_slot_seq

Overview:
- Operator-slot sequencer plus a resettable delay line for the OPL/OPLL register and pipeline front end.
- Cycles through the 18 operator slots (3 groups × 6 sub-slots), advancing once per clock-enable.
- Exposes the slot position in several encodings.
- Carries a parameterised-width bus through a fixed number of clock-enabled pipeline stages, so per-slot data stays aligned with later pipeline stages.

Parameters:
- W, 9: width of the delay-line data bus (≥1).
- STAGES, 3: number of delay stages (≥1).
- RSTVAL, 0: value (W bits, replicated to every stage) loaded into each stage on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- cen  input  1  clock enable; state advances only on edges where cen=1.
- din  input  W  delay-line input.
- drop  output  W  delay-line output (din delayed by STAGES enabled cycles).
- zero  output  1  high while the sequencer is on slot 0 (group 0, sub-slot 0).
- group  output  2  current group, 0..2.
- subslot  output  3  current sub-slot within the group, 0..5.
- op  output  1  0 = modulator (sub-slot 0..2); 1 = carrier (sub-slot 3..5).
- slot  output  18  one-hot slot index; bit n set for slot n = group*6 + subslot.

Behaviour:
- Reset:
  - rst=0 at a rising edge takes priority and acts regardless of cen.
  - Sequencer returns to group=0, subslot=0, slot=18'h00001; hence zero=1, op=0.
  - Every delay stage loads RSTVAL, so drop=RSTVAL from the first edge after reset.
- Sequencer advance (rst=1, cen=1), per edge:
  - subslot<5: subslot+1.
  - subslot=5: subslot→0 and group advances 0→1→2→0.
  - slot rotates left by one position: bit 17 wraps into bit 0.
- Period is exactly 18 enabled cycles.
- cen=0: all state holds; outputs unchanged.
- Derived outputs are combinational functions of the registered state, with no extra latency:
  - zero = slot[0]
  - op = (subslot ≥ 3)
- Invariant: slot is always one-hot and equals 1 << (group*6 + subslot). The implementation keeps both encodings in lock-step.
- Robustness: an illegal group value (3) or subslot value (6/7) on any enabled edge forces the next state to group=0, subslot=0, slot=bit 0.
- Delay line:
  - On each enabled edge, stage0 ← din and stage k ← stage k-1.
  - drop = stage STAGES-1.
  - Latency: a value presented on din at enabled edge N appears on drop immediately after enabled edge N+STAGES-1, i.e. it has passed through STAGES registers.
  - cen=0 freezes all stages; gaps in cen stretch wall-clock latency but never drop or duplicate data.
- Reset mid-operation:
  - Counter restarts at slot 0 on the next edge.
  - Any delay-line contents are discarded and replaced by RSTVAL.
  - The first post-reset enabled edge moves the counter to slot 1.
- Delay line and sequencer share cen and rst but are otherwise independent.

Test Plan:
- Reset, then 1 edge with cen=1 → group=0, subslot=1, slot=18'h00002, zero=0, op=0.
- Apply rst=0 for 1 edge, then hold cen=1 for 18 edges, checking each step:
  - edge 3 → subslot=3, op=1.
  - edge 6 → group=1, subslot=0, slot=18'h00040.
  - edge 17 → group=2, subslot=5, slot=18'h20000.
  - edge 18 → zero=1, slot=18'h00001.
- cen toggled 1,0,0,1 after reset → state advances only on the two enabled edges (final subslot=2). With cen=0 for 10 edges, nothing changes.
- W=9, STAGES=3, RSTVAL=0:
  - Drive din=9'h1A5 for one enabled edge, then 0 → drop=9'h1A5 after the 3rd enabled edge, otherwise 0.
  - Repeat with cen gaps → same ordering, latency counted in enabled edges only.
- Fill the delay line with 9'h1FF, then assert rst=0 with cen=0 → drop=RSTVAL and slot=18'h00001 on the next edge. Also repeat with RSTVAL=9'h0AA → drop=9'h0AA.
- Force an illegal state via hierarchical deposit (group=3) → next enabled edge yields group=0, subslot=0, slot=18'h00001.

Source files
------------

// File: rtl/opl_slot_seq_if.sv
// Front-end bundle between the slot sequencer and its user.
// The master drives the enable and delay-line input; the slave returns the slot position and delayed data.
interface opl_slot_seq_if #(
  parameter int W = 9
);
  logic         cen;
  logic [W-1:0] din;
  logic [W-1:0] drop;
  logic         zero;
  logic [1:0]   group;
  logic [2:0]   subslot;
  logic         op;
  logic [17:0]  slot;

  modport master (
    output cen, din,
    input  drop, zero, group, subslot, op, slot
  );

  modport slave (
    input  cen, din,
    output drop, zero, group, subslot, op, slot
  );
endinterface

// File: rtl/opl_slot_seq.sv
// 18-slot OPL operator sequencer (3 groups x 6 sub-slots) plus an enabled delay line of STAGES registers.
// Outputs are registered state with no extra latency; there is no backpressure, cen=0 simply freezes everything.
module opl_slot_seq #(
  parameter int             W      = 9,
  parameter int             STAGES = 3,
  parameter logic [W-1:0]   RSTVAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  opl_slot_seq_if.slave bus
);

  logic [1:0]   group_q,   group_d;
  logic [2:0]   subslot_q, subslot_d;
  logic [17:0]  slot_q,    slot_d;
  logic [W-1:0] stage_q [STAGES];
  logic [W-1:0] stage_d [STAGES];

  always_comb begin
    group_d   = group_q;
    subslot_d = subslot_q;
    slot_d    = slot_q;
    if (bus.cen) begin
      // Out-of-range counters resynchronise both encodings to slot 0.
      if (group_q == 2'd3 || subslot_q > 3'd5) begin
        group_d   = 2'd0;
        subslot_d = 3'd0;
        slot_d    = 18'h00001;
      end else begin
        slot_d = {slot_q[16:0], slot_q[17]};
        if (subslot_q == 3'd5) begin
          subslot_d = 3'd0;
          group_d   = (group_q == 2'd2) ? 2'd0 : group_q + 2'd1;
        end else begin
          subslot_d = subslot_q + 3'd1;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stage_d[k] = stage_q[k];
    end
    if (bus.cen) begin
      stage_d[0] = bus.din;
      for (int k = 1; k < STAGES; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      group_q   <= 2'd0;
      subslot_q <= 3'd0;
      slot_q    <= 18'h00001;
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= RSTVAL;
      end
    end else begin
      group_q   <= group_d;
      subslot_q <= subslot_d;
      slot_q    <= slot_d;
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign bus.drop    = stage_q[STAGES-1];
  assign bus.zero    = slot_q[0];
  assign bus.group   = group_q;
  assign bus.subslot = subslot_q;
  assign bus.op      = (subslot_q >= 3'd3);
  assign bus.slot    = slot_q;

endmodule

// File: tb/tb_opl_slot_seq.sv
// Bench for opl_slot_seq: directed and random steps checked against a slot-index / queue reference model.
// Two instances share stimulus so both reset values of the delay line are exercised.
module tb_opl_slot_seq;
  localparam int           W      = 9;
  localparam int           STAGES = 3;
  localparam logic [W-1:0] RVA    = 9'h000;
  localparam logic [W-1:0] RVB    = 9'h0AA;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  opl_slot_seq_if #(.W(W)) a_if ();
  opl_slot_seq_if #(.W(W)) b_if ();

  opl_slot_seq #(.W(W), .STAGES(STAGES), .RSTVAL(RVA)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  opl_slot_seq #(.W(W), .STAGES(STAGES), .RSTVAL(RVB)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  int unsigned  vectors    = 0;
  int unsigned  miscompares = 0;

  // Reference: slot index 0..17 plus a queue of the last STAGES enabled inputs (newest first).
  int           n          = 0;
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  bit           force_zero = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    qa.delete();
    qb.delete();
    for (int k = 0; k < STAGES; k++) begin
      qa.push_back(RVA);
      qb.push_back(RVB);
    end
  endtask

  task automatic check_all();
    int sub;
    sub = n % 6;
    chk("group",   32'(a_if.group),   32'(n / 6));
    chk("subslot", 32'(a_if.subslot), 32'(sub));
    chk("slot",    32'(a_if.slot),    32'(1) << n);
    chk("zero",    32'(a_if.zero),    32'(n == 0));
    chk("op",      32'(a_if.op),      32'(sub >= 3));
    chk("drop_a",  32'(a_if.drop),    32'(qa[STAGES-1]));
    chk("drop_b",  32'(b_if.drop),    32'(qb[STAGES-1]));
  endtask

  task automatic step(input logic r, input logic c, input logic [W-1:0] d);
    @(negedge clk);
    rst       = r;
    a_if.cen  = c;
    b_if.cen  = c;
    a_if.din  = d;
    b_if.din  = d;
    @(posedge clk);
    if (!r) begin
      model_reset();
      force_zero = 1'b0;
    end else if (c) begin
      n = force_zero ? 0 : (n + 1) % 18;
      force_zero = 1'b0;
      qa.push_front(d);
      void'(qa.pop_back());
      qb.push_front(d);
      void'(qb.pop_back());
    end
    #1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.cen = 1'b0;
    b_if.cen = 1'b0;
    a_if.din = '0;
    b_if.din = '0;
    model_reset();

    // Reset state, then one enabled edge to slot 1.
    step(1'b0, 1'b1, 9'h155);
    step(1'b0, 1'b0, 9'h000);
    step(1'b1, 1'b1, 9'h000);
    chk("first_slot", 32'(a_if.slot), 32'h00002);

    // Full period of 18 enabled edges from reset.
    step(1'b0, 1'b0, 9'h000);
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 1'b1, 9'h000);
      if (i == 5)  chk("edge6_slot",  32'(a_if.slot), 32'h00040);
      if (i == 16) chk("edge17_slot", 32'(a_if.slot), 32'h20000);
    end
    chk("wrap_zero", 32'(a_if.zero), 32'd1);

    // cen 1,0,0,1 after reset, then a long disabled stretch.
    step(1'b0, 1'b1, 9'h000);
    step(1'b1, 1'b1, 9'h000);
    step(1'b1, 1'b0, 9'h000);
    step(1'b1, 1'b0, 9'h000);
    step(1'b1, 1'b1, 9'h000);
    chk("gated_subslot", 32'(a_if.subslot), 32'd2);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 9'h1FF);

    // Single pulse through the delay line, with and without enable gaps.
    step(1'b0, 1'b0, 9'h000);
    step(1'b1, 1'b1, 9'h1A5);
    step(1'b1, 1'b1, 9'h000);
    step(1'b1, 1'b1, 9'h000);
    chk("pulse_lat3", 32'(a_if.drop), 32'h1A5);
    step(1'b1, 1'b1, 9'h000);
    step(1'b1, 1'b1, 9'h1A5);
    step(1'b1, 1'b0, 9'h000);
    step(1'b1, 1'b1, 9'h000);
    step(1'b1, 1'b0, 9'h000);
    step(1'b1, 1'b0, 9'h000);
    step(1'b1, 1'b1, 9'h000);
    chk("pulse_gaps", 32'(a_if.drop), 32'h1A5);
    step(1'b1, 1'b1, 9'h000);

    // Random enable, data and occasional reset.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 24) != 0), ($urandom_range(0, 2) != 0),
           W'($urandom_range(0, 511)));
    end

    // Fill with all-ones, then reset with cen low.
    for (int i = 0; i < STAGES; i++) step(1'b1, 1'b1, 9'h1FF);
    step(1'b0, 1'b0, 9'h1FF);
    chk("rst_drop_a", 32'(a_if.drop), 32'(RVA));
    chk("rst_drop_b", 32'(b_if.drop), 32'h0AA);
    chk("rst_slot",   32'(a_if.slot), 32'h00001);

    // Illegal group value resynchronises to slot 0 on the next enabled edge.
    step(1'b1, 1'b1, 9'h000);
    step(1'b1, 1'b1, 9'h000);
    step(1'b1, 1'b0, 9'h000);
    @(negedge clk);
    force dut_a.group_q = 2'd3;
    #1;
    release dut_a.group_q;
    force_zero = 1'b1;
    step(1'b1, 1'b1, 9'h000);
    chk("illegal_slot", 32'(a_if.slot), 32'h00001);
    step(1'b1, 1'b1, 9'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
